// File: rtl/fifo_drainer.sv
// fifo_drainer
//   Pops words from a FIFO and writes them to consecutive memory addresses:
//   base_addr, base_addr+step, ... up to end_addr inclusive. The run also ends
//   when the next address would carry out of AW bits.
//   Each word takes two cycles: POP (r_en), then WRITE (mem_cs/mem_we).
//
// Optional feature: define FIFO_DRAINER_CNT_EN to add the word_cnt output.
//
// Ports
//   clk, rstn           clock, asynchronous active-low reset
//   start               begin a run (sampled in IDLE only)
//   base_addr           first write address      (latched on accepted start)
//   addr_step           address increment, 0->1  (latched on accepted start)
//   end_addr            last legal address, incl (latched on accepted start)
//   empty, from_fifo    FIFO status / read data (data valid the cycle after r_en)
//   r_en                FIFO pop strobe, never asserted while empty=1
//   mem_cs, mem_we      memory strobes, high only in WRITE
//   mem_addr, mem_wdata memory address / data, zero outside WRITE
//   busy                high in any state other than IDLE
//   done                one-cycle pulse in FINISH
//   dbg_state           one-hot FSM state for observation
//   word_cnt            words written in the current/last run (FIFO_DRAINER_CNT_EN)
//
// Handshake: the FIFO side is a pop strobe; r_en=1 in a cycle means one word is
// consumed at the next rising edge, and that word is presented on from_fifo in
// the following cycle. There is no back-pressure on the memory side: a word is
// written in the single cycle mem_cs=mem_we=1.
module fifo_drainer #(
  parameter int WIDTH = 16,
  parameter int AW    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW-1:0]    addr_step,
  input  logic [AW-1:0]    end_addr,
  input  logic             empty,
  input  logic [WIDTH-1:0] from_fifo,
  output logic             r_en,
  output logic             mem_cs,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             busy,
  output logic             done,
  output logic [3:0]       dbg_state
`ifdef FIFO_DRAINER_CNT_EN
  ,
  output logic [AW-1:0]    word_cnt
`endif
);

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    POP    = 4'b0010,
    WRITE  = 4'b0100,
    FINISH = 4'b1000
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   addr;
  logic [AW-1:0]   step_q;
  logic [AW-1:0]   end_q;
  logic [AW:0]     next_sum;
  logic            start_ok;
  logic            last_word;

  // A start whose range is empty (base above end) is not a run at all.
  assign start_ok  = start && (base_addr <= end_addr);

  // One extra bit so a carry out of AW bits is seen as "past the end".
  assign next_sum  = {1'b0, addr} + {1'b0, step_q};
  assign last_word = next_sum > {1'b0, end_q};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      addr   <= '0;
      step_q <= '0;
      end_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start_ok) begin
        addr   <= base_addr;
        step_q <= (addr_step == '0) ? AW'(1) : addr_step;
        end_q  <= end_addr;
      end else if (state == WRITE && !last_word) begin
        addr <= next_sum[AW-1:0];
      end
    end
  end

`ifdef FIFO_DRAINER_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_cnt <= '0;
    end else if (state == IDLE && start_ok) begin
      word_cnt <= '0;
    end else if (state == WRITE) begin
      word_cnt <= word_cnt + AW'(1);
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    r_en      = 1'b0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_ok) state_nxt = POP;
      end
      POP: begin
        // Stay here for as long as the FIFO is empty; pop only when it is not.
        if (!empty) begin
          r_en      = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        mem_cs    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr;
        mem_wdata = from_fifo;
        state_nxt = last_word ? FINISH : POP;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign dbg_state = state;

endmodule
